// File: rtl/imem_port_arbiter_pkg.sv
// Shared types for the instruction-memory port arbiter: FSM states,
// requester identities and byte-cycle helpers.
package imem_arb_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        B0   = 3'd1,
        B1   = 3'd2,
        B2   = 3'd3,
        B3   = 3'd4,
        RESP = 3'd5
    } state_e;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_LOAD  = 1'b1
    } requester_e;

    // Byte offset from the base address handled in a byte-cycle state.
    function automatic logic [1:0] byte_index(input state_e s);
        logic [1:0] k;
        k = 2'd0;
        case (s)
            B1:      k = 2'd1;
            B2:      k = 2'd2;
            B3:      k = 2'd3;
            default: k = 2'd0;
        endcase
        return k;
    endfunction

    // True in the four states that touch the memory array.
    function automatic logic is_byte_state(input state_e s);
        return (s == B0) || (s == B1) || (s == B2) || (s == B3);
    endfunction

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Bundle of the fetch, loader and byte-memory signals around the arbiter.
// slave = arbiter side, master = requesters plus memory model side.
interface imem_port_arbiter_if #(
    parameter int ADDR_W = 12
);
    logic              fetch_valid;
    logic [31:0]       fetch_addr;
    logic              fetch_ready;
    logic              fetch_rvalid;
    logic [31:0]       fetch_rdata;

    logic              load_valid;
    logic [31:0]       load_addr;
    logic [31:0]       load_wdata;
    logic              load_ready;
    logic              load_done;

    logic              busy;

    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic [7:0]        mem_rdata;

    modport slave (
        input  fetch_valid, fetch_addr, load_valid, load_addr, load_wdata, mem_rdata,
        output fetch_ready, fetch_rvalid, fetch_rdata, load_ready, load_done, busy,
               mem_addr, mem_wdata, mem_we
    );

    modport master (
        output fetch_valid, fetch_addr, load_valid, load_addr, load_wdata, mem_rdata,
        input  fetch_ready, fetch_rvalid, fetch_rdata, load_ready, load_done, busy,
               mem_addr, mem_wdata, mem_we
    );

endinterface

// File: rtl/imem_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter between fetch and loader. The pointer
// remembers the last requester granted and only moves on an accepted grant.
module imem_rr_arb2
    import imem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_fetch_i,
    input  logic req_load_i,
    input  logic advance_i,
    output logic gnt_fetch_o,
    output logic gnt_load_o
);

    requester_e last_q;
    requester_e last_d;

    // A lone requester wins; on contention the one not granted last wins.
    always_comb begin
        gnt_fetch_o = 1'b0;
        gnt_load_o  = 1'b0;
        if (req_fetch_i && req_load_i) begin
            if (last_q == REQ_LOAD) begin
                gnt_fetch_o = 1'b1;
            end else begin
                gnt_load_o = 1'b1;
            end
        end else begin
            gnt_fetch_o = req_fetch_i;
            gnt_load_o  = req_load_i;
        end

        last_d = last_q;
        if (advance_i) begin
            last_d = gnt_load_o ? REQ_LOAD : REQ_FETCH;
        end
    end

    // Pointer register; reset marks fetch as last so the loader is favoured first.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= REQ_FETCH;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares a byte-wide big-endian instruction memory between the fetch stage
// (word reads) and the program loader (word writes). Each word access is four
// byte cycles, MSB first, followed by a one-cycle response.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    imem_port_arbiter_if.slave   bus
);

    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(DEPTH - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] base_q,  base_d;
    requester_e        op_q,    op_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [23:0]       asm_q,   asm_d;
    logic [31:0]       rdata_q, rdata_d;

    logic              gnt_fetch;
    logic              gnt_load;
    logic              accept_fetch;
    logic              accept_load;
    logic              idle;
    logic [1:0]        k;
    logic [1:0]        lane;
    logic [7:0]        wdata_lane [BYTES_PER_WORD];

    // Only the low ADDR_W address bits select a byte; the rest are don't-care.
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{bus.fetch_addr[31:ADDR_W], bus.load_addr[31:ADDR_W]};

    assign idle = (state_q == IDLE);
    assign k    = byte_index(state_q);
    assign lane = 2'd3 - k;

    // Byte lanes of the latched write word, lane 3 being bits [31:24].
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_wlane
        assign wdata_lane[gi] = wdata_q[8*gi +: 8];
    end

    imem_rr_arb2 u_arb (
        .clk         (clk),
        .rst         (rst),
        .req_fetch_i (bus.fetch_valid),
        .req_load_i  (bus.load_valid),
        .advance_i   (accept_fetch | accept_load),
        .gnt_fetch_o (gnt_fetch),
        .gnt_load_o  (gnt_load)
    );

    // Grants only count in IDLE and never while reset is held.
    assign accept_fetch = idle && !rst && gnt_fetch;
    assign accept_load  = idle && !rst && gnt_load;

    // Next-state, byte sequencing and memory/response outputs.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        op_d    = op_q;
        wdata_d = wdata_q;
        asm_d   = asm_q;
        rdata_d = rdata_q;

        bus.fetch_ready  = accept_fetch;
        bus.load_ready   = accept_load;
        bus.fetch_rvalid = 1'b0;
        bus.load_done    = 1'b0;
        bus.mem_addr     = '0;
        bus.mem_wdata    = 8'h00;
        bus.mem_we       = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_fetch) begin
                    base_d  = bus.fetch_addr[ADDR_W-1:0];
                    op_d    = REQ_FETCH;
                    state_d = B0;
                end else if (accept_load) begin
                    base_d  = bus.load_addr[ADDR_W-1:0];
                    op_d    = REQ_LOAD;
                    wdata_d = bus.load_wdata;
                    state_d = B0;
                end
            end
            B0, B1, B2, B3: begin
                // Address wraps at the top of memory; unaligned bases are fine.
                bus.mem_addr = (base_q + ADDR_W'(k)) & ADDR_MASK;
                if (op_q == REQ_LOAD) begin
                    bus.mem_wdata = wdata_lane[lane];
                    // A reset landing mid-write suppresses the pending byte.
                    bus.mem_we    = !rst;
                end else if (state_q == B3) begin
                    // Publish the whole word at once so fetch_rdata never shows a partial read.
                    rdata_d = {asm_q, bus.mem_rdata};
                end else begin
                    asm_d[{lane - 2'd1, 3'b000} +: 8] = bus.mem_rdata;
                end
                case (state_q)
                    B0:      state_d = B1;
                    B1:      state_d = B2;
                    B2:      state_d = B3;
                    default: state_d = RESP;
                endcase
            end
            RESP: begin
                bus.fetch_rvalid = (op_q == REQ_FETCH);
                bus.load_done    = (op_q == REQ_LOAD);
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy        = !idle;
    assign bus.fetch_rdata = rdata_q;

    // Transaction state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            op_q    <= REQ_FETCH;
            wdata_q <= 32'h0;
            asm_q   <= 24'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            op_q    <= op_d;
            wdata_q <= wdata_d;
            asm_q   <= asm_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed bench for imem_port_arbiter: a byte memory model, a cycle-level
// behavioural reference checked every cycle, and literal expectations.
module tb_imem_port_arbiter;

    logic clk;
    logic rst;

    imem_port_arbiter_if #(.ADDR_W(12)) bus ();

    imem_port_arbiter #(.ADDR_W(12), .DEPTH(4096)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory array seen by the DUT.
    logic [7:0] env_mem [4096];
    assign bus.mem_rdata = env_mem[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_we) env_mem[bus.mem_addr] <= bus.mem_wdata;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference ----------------
    // phase 0 = idle, 1..4 = byte cycles of the current word, 5 = response.
    logic [7:0]  ref_mem [4096];
    bit          model_on = 0;
    int          m_phase  = 0;
    int          m_base   = 0;
    bit          m_write  = 0;
    bit          m_last_load = 0;
    logic [31:0] m_wdata  = 0;
    logic [31:0] m_rdata  = 0;

    always @(negedge clk) begin : model
        logic        e_fr, e_lr, e_we, e_rv, e_done, e_busy;
        logic [11:0] e_addr;
        logic [7:0]  e_wd;
        if (model_on) begin
            e_fr = 0; e_lr = 0;
            if (m_phase == 0 && !rst) begin
                if (bus.fetch_valid && bus.load_valid) begin
                    if (m_last_load) e_fr = 1; else e_lr = 1;
                end else begin
                    e_fr = bus.fetch_valid;
                    e_lr = bus.load_valid;
                end
            end
            e_busy = (m_phase != 0);
            e_addr = (m_phase >= 1 && m_phase <= 4) ? 12'((m_base + m_phase - 1) % 4096) : 12'd0;
            e_we   = (m_phase >= 1 && m_phase <= 4) && m_write && !rst;
            e_wd   = (m_phase >= 1 && m_phase <= 4 && m_write) ? 8'(m_wdata >> (8 * (4 - m_phase))) : 8'h00;
            e_rv   = (m_phase == 5) && !m_write;
            e_done = (m_phase == 5) && m_write;

            check("fetch_ready",  bus.fetch_ready,  e_fr);
            check("load_ready",   bus.load_ready,   e_lr);
            check("busy",         bus.busy,         e_busy);
            check("mem_addr",     bus.mem_addr,     e_addr);
            check("mem_we",       bus.mem_we,       e_we);
            check("mem_wdata",    bus.mem_wdata,    e_wd);
            check("fetch_rvalid", bus.fetch_rvalid, e_rv);
            check("load_done",    bus.load_done,    e_done);
            check("fetch_rdata",  bus.fetch_rdata,  m_rdata);

            if (rst) begin
                m_phase = 0; m_last_load = 0; m_rdata = 0;
            end else if (m_phase == 0) begin
                if (e_fr || e_lr) begin
                    m_write     = e_lr;
                    m_last_load = e_lr;
                    m_base      = e_lr ? int'(bus.load_addr % 4096) : int'(bus.fetch_addr % 4096);
                    m_wdata     = bus.load_wdata;
                    m_phase     = 1;
                end
            end else if (m_phase <= 4) begin
                if (m_write) ref_mem[int'(e_addr)] = e_wd;
                if (m_phase == 4 && !m_write)
                    m_rdata = {ref_mem[m_base], ref_mem[(m_base + 1) % 4096],
                               ref_mem[(m_base + 2) % 4096], ref_mem[(m_base + 3) % 4096]};
                m_phase++;
            end else begin
                m_phase = 0;
            end
        end
    end

    // ---------------- contention monitor ----------------
    bit       cont_on = 0;
    int       n_grants = 0;
    logic [3:0] grant_log = 4'b0;

    always @(negedge clk) begin
        if (cont_on) begin
            check("ready_exclusive", bus.fetch_ready & bus.load_ready, 1'b0);
            if ((bus.fetch_ready || bus.load_ready) && n_grants < 4) begin
                grant_log[3 - n_grants] = bus.load_ready;
                n_grants++;
            end
        end
    end

    // ---------------- directed transactions ----------------
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] exp_word, input logic [47:0] exp_seq);
        int n;
        logic [47:0] seq;
        @(posedge clk); #1;
        bus.fetch_valid = 1; bus.fetch_addr = a;
        n = 0;
        @(negedge clk);
        while (!bus.fetch_ready && n < 40) begin @(negedge clk); n++; end
        check("fetch_handshake", bus.fetch_ready, 1'b1);
        @(posedge clk); #1;
        bus.fetch_valid = 0;
        seq = '0; n = 0;
        @(negedge clk);
        while (!bus.fetch_rvalid && n < 10) begin
            if (n < 4) seq[47 - 12*n -: 12] = bus.mem_addr;
            n++;
            @(negedge clk);
        end
        check("fetch_addr_seq", seq, exp_seq);
        check("fetch_latency", n, 4);
        check("fetch_rvalid_seen", bus.fetch_rvalid, 1'b1);
        check("fetch_word", bus.fetch_rdata, exp_word);
        $display("[TB] fetch addr=%08h data=%08h", a, bus.fetch_rdata);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [31:0] w, input logic [47:0] exp_seq);
        int n;
        logic [47:0] seq;
        logic [31:0] bytes;
        logic [3:0]  wes;
        @(posedge clk); #1;
        bus.load_valid = 1; bus.load_addr = a; bus.load_wdata = w;
        n = 0;
        @(negedge clk);
        while (!bus.load_ready && n < 40) begin @(negedge clk); n++; end
        check("load_handshake", bus.load_ready, 1'b1);
        @(posedge clk); #1;
        bus.load_valid = 0;
        seq = '0; bytes = '0; wes = '0; n = 0;
        @(negedge clk);
        while (!bus.load_done && n < 10) begin
            if (n < 4) begin
                seq[47 - 12*n -: 12] = bus.mem_addr;
                bytes[31 - 8*n -: 8] = bus.mem_wdata;
                wes[3 - n]           = bus.mem_we;
            end
            n++;
            @(negedge clk);
        end
        check("load_addr_seq", seq, exp_seq);
        check("load_bytes", bytes, w);
        check("load_we", wes, 4'b1111);
        check("load_latency", n, 4);
        check("load_done_seen", bus.load_done, 1'b1);
        $display("[TB] load addr=%08h data=%08h", a, w);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            env_mem[i] = 8'(i ^ 8'h5A);
            ref_mem[i] = 8'(i ^ 8'h5A);
        end
        env_mem[0] = 8'h00; env_mem[1] = 8'h22; env_mem[2] = 8'h18; env_mem[3] = 8'h21;
        env_mem[4] = 8'h01; env_mem[5] = 8'h02; env_mem[6] = 8'h03; env_mem[7] = 8'h04;
        env_mem[4094] = 8'hDE; env_mem[4095] = 8'hAD;
        for (int i = 16; i < 20; i++) env_mem[i] = 8'h11;
        for (int i = 0; i < 4096; i++) ref_mem[i] = env_mem[i];

        rst = 1;
        bus.fetch_valid = 0; bus.fetch_addr = 0;
        bus.load_valid  = 0; bus.load_addr  = 0; bus.load_wdata = 0;
        @(posedge clk); #1;
        model_on = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        do_fetch(32'd0, 32'h00221821, {12'd0, 12'd1, 12'd2, 12'd3});
        do_load(32'd8, 32'h00232021, {12'd8, 12'd9, 12'd10, 12'd11});
        check("mem8",  env_mem[8],  8'h00);
        check("mem9",  env_mem[9],  8'h23);
        check("mem10", env_mem[10], 8'h20);
        check("mem11", env_mem[11], 8'h21);
        do_fetch(32'd8, 32'h00232021, {12'd8, 12'd9, 12'd10, 12'd11});
        do_fetch(32'd4094, 32'hDEAD0022, {12'd4094, 12'd4095, 12'd0, 12'd1});
        do_fetch(32'h0000_1004, 32'h01020304, {12'd4, 12'd5, 12'd6, 12'd7});

        // Contention straight after reset: loader should win first.
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        bus.fetch_valid = 1; bus.fetch_addr = 0;
        bus.load_valid  = 1; bus.load_addr  = 20; bus.load_wdata = 32'h12345678;
        cont_on = 1;
        for (int c = 0; c < 60 && n_grants < 4; c++) @(negedge clk);
        @(posedge clk); #1;
        bus.fetch_valid = 0; bus.load_valid = 0;
        repeat (8) @(posedge clk);
        cont_on = 0;
        check("grant_count", n_grants, 4);
        check("grant_order", grant_log, 4'b1010);
        $display("[TB] contention grants=%0d order(load=1)=%b", n_grants, grant_log);

        // Reset landing in B2 of a write to 16.
        @(posedge clk); #1;
        bus.load_valid = 1; bus.load_addr = 16; bus.load_wdata = 32'hAABBCCDD;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!bus.load_ready && n < 40) begin @(negedge clk); n++; end
            check("rst_load_handshake", bus.load_ready, 1'b1);
        end
        @(posedge clk); #1 bus.load_valid = 0;
        @(posedge clk);
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        check("rst_b2_we", bus.mem_we, 1'b0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        check("rst_idle_busy", bus.busy, 1'b0);
        check("rst_idle_done", bus.load_done, 1'b0);
        check("rst_idle_rdata", bus.fetch_rdata, 32'h0);
        check("rst_mem16", env_mem[16], 8'hAA);
        check("rst_mem17", env_mem[17], 8'hBB);
        check("rst_mem18", env_mem[18], 8'h11);
        check("rst_mem19", env_mem[19], 8'h11);
        $display("[TB] reset mid-write bytes16..19=%02h %02h %02h %02h",
                 env_mem[16], env_mem[17], env_mem[18], env_mem[19]);

        do_fetch(32'd16, 32'hAABB1111, {12'd16, 12'd17, 12'd18, 12'd19});

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_port_arbiter.md
Name: imem_port_arbiter

Overview:
- Shares one single-port, byte-wide, big-endian instruction memory (4096 bytes) between two requesters:
  - the fetch stage, which reads 32-bit words;
  - the program loader, which writes 32-bit words.
- Sequences each word access as four byte cycles, assembling or splitting words MSB-first. The byte at addr is bits [31:24].
- Sits between the IF stage / loader and the instruction memory array; replaces direct combinational word reads.

Parameters:
- ADDR_W, 12, byte-address width of the memory.
- DEPTH, 4096, bytes in the memory (2**ADDR_W).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- fetch_valid  in  1  fetch read request
- fetch_addr  in  32  fetch byte address; only [ADDR_W-1:0] used
- fetch_ready  out  1  fetch request accepted this cycle
- fetch_rvalid  out  1  one-cycle pulse, fetch_rdata valid
- fetch_rdata  out  32  assembled word
- load_valid  in  1  loader write request
- load_addr  in  32  loader byte address; only [ADDR_W-1:0] used
- load_wdata  in  32  word to write
- load_ready  out  1  loader request accepted this cycle
- load_done  out  1  one-cycle pulse, write completed
- busy  out  1  transaction in progress
- mem_addr  out  ADDR_W  byte address to memory
- mem_wdata  out  8  byte to write
- mem_we  out  1  byte write enable
- mem_rdata  in  8  combinational read data for mem_addr

Behaviour:
- Reset values: all outputs 0; state IDLE; round-robin pointer favours the loader first; fetch_rdata register cleared.
- States: IDLE, B0, B1, B2, B3, RESP.
- IDLE:
  - fetch_ready = fetch_valid & grant_fetch; load_ready = load_valid & grant_load. Both are combinational and are never high together.
  - On a handshake, latch addr[ADDR_W-1:0], op, and wdata; go to B0.
- Arbitration:
  - Only one requester valid: that requester wins.
  - Both valid: round-robin; the winner is the requester not granted last, then the pointer flips.
  - Evaluated only in IDLE; the transaction is locked until RESP.
- Bk (k=0..3):
  - mem_addr = (base + k) mod DEPTH; wrap-around is legal; alignment is not required.
  - Read: capture mem_rdata into byte lane 3-k of fetch_rdata (B0 gives [31:24]).
  - Write: mem_wdata = wdata byte lane 3-k; mem_we = 1.
  - mem_we is 0 in every other state and for reads.
- RESP:
  - Pulse fetch_rvalid (read) or load_done (write) for exactly one cycle; return to IDLE.
  - fetch_rdata holds its value until the next read completes.
- Latency: handshake in cycle T → byte cycles T+1..T+4 → rvalid/done in T+5 → next handshake possible in T+6. Throughput is one word per 6 cycles.
- busy = 1 in B0..RESP, 0 in IDLE.
- While busy, request inputs are ignored. A requester holds valid until ready.
- Reset mid-transaction: return to IDLE next cycle with no rvalid/done pulse and mem_we deasserted. Bytes already written stay written; the partial write is not rolled back.
- Address bits above ADDR_W-1 are ignored.

Decomposition:
- Package imem_arb_pkg:
  - state enum (IDLE, B0..B3, RESP);
  - requester enum (REQ_FETCH, REQ_LOAD);
  - BYTES_PER_WORD = 4.
- One sub-module is natural: imem_rr_arb2, a 2-way round-robin arbiter with an update-on-grant pointer.

Test Plan:
- Read: mem bytes 0..3 = 00,22,18,21; fetch_valid with addr 0 → fetch_ready in cycle T, mem_addr 0,1,2,3 in T+1..T+4, fetch_rvalid in T+5 with fetch_rdata = 32'h00221821.
- Write: load_addr 8, wdata 32'h00232021 → mem_we high T+1..T+4 with bytes 00,23,20,21 at addr 8..11; load_done in T+5. A following fetch of addr 8 returns 32'h00232021.
- Contention: both valid continuously after reset → grants alternate load, fetch, load, fetch; fetch_ready and load_ready are never both high; busy is low only in the grant cycles.
- Wrap: fetch addr 4094 → mem_addr sequence 4094, 4095, 0, 1; word assembled in that order.
- Reset in B2 of a write to addr 16 → no load_done; bytes 16 and 17 updated, 18 and 19 unchanged; next cycle IDLE with all outputs 0.
- Upper address bits: fetch addr 32'h0000_1004 → mem_addr starts at 4.
